// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// irq_ctrl : level/edge interrupt controller with a priority claim/complete
//            register interface driving a single registered irq line.
// Revision : 1.0
// ============================================================================
module irq_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src,
  input  logic             re,
  input  logic             we,
  input  logic [3:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq
);

  localparam logic [1:0] C_REG_PENDING = 2'd0;
  localparam logic [1:0] C_REG_ENABLE  = 2'd1;
  localparam logic [1:0] C_REG_EDGE    = 2'd2;
  localparam logic [1:0] C_REG_CLAIM   = 2'd3;

  logic [N_SRC-1:0] s1_q, s1_d;
  logic [N_SRC-1:0] s2_q, s2_d;
  logic [N_SRC-1:0] s_prev_q, s_prev_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] in_service_q, in_service_d;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] edge_q, edge_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d;

  logic [1:0]       w_sel;
  logic             w_rd;
  logic             w_wr;
  logic [N_SRC-1:0] w_eligible;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_claim_hit;
  logic [N_SRC-1:0] w_complete_hit;
  logic [31:0]      w_claim_id;
  logic             w_claim_fire;
  logic             unused_addr_lsb;

  assign w_sel           = addr[3:2];
  // A simultaneous write takes priority, so only a lone re counts as a read.
  assign w_rd            = re & ~we;
  assign w_wr            = we;
  assign w_eligible      = pending_q & enable_q & ~in_service_q;
  assign w_rise          = s2_q & ~s_prev_q;
  assign w_w1c           = (w_wr && (w_sel == C_REG_PENDING)) ? wdata[N_SRC-1:0] : '0;
  assign unused_addr_lsb = ^addr[1:0];

  // Lowest index wins: scan downward so the last hit is the lowest index.
  always_comb begin
    w_claim_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_claim_id = i + 1;
      end
    end
  end

  assign w_claim_fire = w_rd && (w_sel == C_REG_CLAIM) && (w_claim_id != '0);

  generate
    for (genvar i = 0; i < N_SRC; i++) begin : g_src
      assign w_claim_hit[i]    = w_claim_fire && (w_claim_id == 32'(i + 1));
      assign w_complete_hit[i] = w_wr && (w_sel == C_REG_CLAIM) && (wdata == 32'(i + 1));
    end
  endgenerate

  always_comb begin
    s1_d         = src;
    s2_d         = s1_q;
    s_prev_d     = s2_q;
    enable_d     = enable_q;
    edge_d       = edge_q;
    irq_d        = |w_eligible;
    rdata_d      = rdata_q;
    in_service_d = (in_service_q | w_claim_hit) & ~w_complete_hit;

    // Edge sources: a fresh rising edge beats a same-cycle claim/W1C clear.
    pending_d = (edge_q & (w_rise | (pending_q & ~(w_claim_hit | w_w1c))))
              | (~edge_q & s2_q);

    if (w_wr && (w_sel == C_REG_ENABLE)) begin
      enable_d = wdata[N_SRC-1:0];
    end

    if (w_wr && (w_sel == C_REG_EDGE)) begin
      edge_d    = wdata[N_SRC-1:0];
      pending_d = pending_d & ~(edge_q ^ wdata[N_SRC-1:0]);
    end

    if (re && we) begin
      rdata_d = '0;
    end else if (re) begin
      case (w_sel)
        C_REG_PENDING: rdata_d = 32'(pending_q);
        C_REG_ENABLE:  rdata_d = 32'(enable_q);
        C_REG_EDGE:    rdata_d = 32'(edge_q);
        default:       rdata_d = w_claim_id;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= '0;
      s2_q         <= '0;
      s_prev_q     <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      enable_q     <= '0;
      edge_q       <= '0;
      rdata_q      <= '0;
      irq_q        <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s_prev_q     <= s_prev_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      enable_q     <= enable_d;
      edge_q       <= edge_d;
      rdata_q      <= rdata_d;
      irq_q        <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_irq_ctrl : directed scenarios plus randomized traffic against a model.
// Revision    : 1.0
// ============================================================================
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  src = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: hist[k] is src as sampled k+1 edges ago.
  logic [7:0]  m_hist [3];
  logic [7:0]  m_pend, m_isv, m_en, m_edge;
  logic [31:0] m_rdata;
  logic        m_irq;

  irq_ctrl #(.N_SRC(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .src   (src),
    .re    (re),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0; wdata = '0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    d = rdata;
  endtask

  task automatic do_reset();
    src = '0; re = 1'b0; we = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_hist[k] = '0;
    m_pend = '0; m_isv = '0; m_en = '0; m_edge = '0;
    m_rdata = '0; m_irq = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] s, input logic r, input logic w,
                            input logic [3:0] a, input logic [31:0] d);
    logic [7:0]  elig, claimed, npend, nisv, nen, nedge, sync, prev;
    logic [31:0] nrd;
    logic        found;
    int          id;
    sync = m_hist[1]; prev = m_hist[2];
    elig = m_pend & m_en & ~m_isv;
    claimed = '0; nrd = m_rdata; nen = m_en; nedge = m_edge; nisv = m_isv;
    found = 1'b0;
    if (r && w) nrd = 0;
    else if (r) begin
      case (a[3:2])
        2'd0: nrd = {24'd0, m_pend};
        2'd1: nrd = {24'd0, m_en};
        2'd2: nrd = {24'd0, m_edge};
        default: begin
          nrd = 0;
          for (int i = 0; i < 8; i++)
            if (!found && elig[i]) begin nrd = i + 1; claimed[i] = 1'b1; found = 1'b1; end
        end
      endcase
    end
    if (w) begin
      case (a[3:2])
        2'd1: nen = d[7:0];
        2'd2: nedge = d[7:0];
        2'd3: begin
          id = int'(d);
          if (d >= 1 && d <= 8) nisv[id-1] = 1'b0;
        end
        default: ;
      endcase
    end
    nisv = nisv | claimed;
    for (int i = 0; i < 8; i++) begin
      if (m_edge[i])
        npend[i] = (sync[i] && !prev[i]) ||
                   (m_pend[i] && !(claimed[i] || (w && a[3:2] == 2'd0 && d[i])));
      else
        npend[i] = sync[i];
    end
    if (w && a[3:2] == 2'd2) npend = npend & ~(m_edge ^ d[7:0]);
    m_irq = |elig;
    m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = s;
    m_pend = npend; m_isv = nisv; m_en = nen; m_edge = nedge; m_rdata = nrd;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b need 0", irq); end
    for (int r = 0; r < 4; r++) begin
      rd(4'(r * 4), v);
      n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL rst_reg%0d: got %0h need 0", r, v); end
    end
  endtask

  task automatic test_level();
    logic [31:0] v;
    do_reset();
    wr(4'h4, 32'h01);
    src = 8'h01;
    tick(); tick(); tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL lvl_early: got %b need 0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL lvl_rise4: got %b need 1", irq); end
    rd(4'hC, v);
    n_cmp++; if (v !== 32'd1) begin n_err++; $display("FAIL lvl_claim: got %0h need 1", v); end
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL lvl_claim_irq: got %b need 0", irq); end
    wr(4'hC, 32'd1);
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL lvl_reraise: got %b need 1", irq); end
    rd(4'hC, v);
    tick();
    src = 8'h00;
    tick(); tick(); tick();
    wr(4'hC, 32'd1);
    tick(); tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL lvl_dropped: got %b need 0", irq); end
  endtask

  task automatic test_priority();
    logic [31:0] v;
    do_reset();
    wr(4'h4, 32'hFF);
    src = 8'h24;
    tick(); tick(); tick(); tick();
    rd(4'hC, v);
    n_cmp++; if (v !== 32'd3) begin n_err++; $display("FAIL pri_first: got %0h need 3", v); end
    rd(4'hC, v);
    n_cmp++; if (v !== 32'd6) begin n_err++; $display("FAIL pri_second: got %0h need 6", v); end
    rd(4'hC, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL pri_empty: got %0h need 0", v); end
    wr(4'hC, 32'd3);
    rd(4'hC, v);
    n_cmp++; if (v !== 32'd3) begin n_err++; $display("FAIL pri_again: got %0h need 3", v); end
  endtask

  task automatic test_edge_latch();
    logic [31:0] v;
    do_reset();
    wr(4'h8, 32'h10);
    wr(4'h4, 32'h10);
    src = 8'h10; tick(); tick(); src = 8'h00;
    tick(); tick(); tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL edge_irq: got %b need 1", irq); end
    rd(4'hC, v);
    n_cmp++; if (v !== 32'd5) begin n_err++; $display("FAIL edge_claim: got %0h need 5", v); end
    tick();
    src = 8'h10; tick(); tick(); src = 8'h00;
    tick(); tick(); tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL edge_insvc_irq: got %b need 0", irq); end
    rd(4'h0, v);
    n_cmp++; if (v !== 32'h10) begin n_err++; $display("FAIL edge_relatch: got %0h need 10", v); end
    wr(4'hC, 32'd5);
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL edge_complete: got %b need 1", irq); end
    wr(4'h0, 32'h10);
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL edge_w1c_irq: got %b need 0", irq); end
    rd(4'h0, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL edge_w1c_pend: got %0h need 0", v); end
  endtask

  task automatic test_set_vs_w1c();
    logic [31:0] v;
    do_reset();
    wr(4'h8, 32'h10);
    src = 8'h10;
    tick(); tick();
    wr(4'h0, 32'h10);
    rd(4'h0, v);
    n_cmp++; if (v !== 32'h10) begin n_err++; $display("FAIL set_wins: got %0h need 10", v); end
    src = 8'h00;
  endtask

  task automatic test_bad_complete();
    logic [31:0] v;
    do_reset();
    wr(4'h4, 32'h01);
    src = 8'h01;
    tick(); tick(); tick(); tick();
    rd(4'hC, v);
    tick();
    wr(4'hC, 32'd0);
    wr(4'hC, 32'd9);
    tick(); tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL badid_irq: got %b need 0", irq); end
    rd(4'hC, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL badid_claim: got %0h need 0", v); end
    wr(4'hC, 32'd1);
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL badid_good: got %b need 1", irq); end
  endtask

  task automatic test_re_we();
    logic [31:0] v;
    do_reset();
    wr(4'h4, 32'h02);
    src = 8'h02;
    tick(); tick(); tick(); tick();
    rd(4'h4, v);
    addr = 4'hC; wdata = 32'd0; re = 1'b1; we = 1'b1;
    tick();
    re = 1'b0; we = 1'b0;
    n_cmp++; if (rdata !== 32'd0) begin n_err++; $display("FAIL rewe_rdata: got %0h need 0", rdata); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL rewe_noclaim: got %b need 1", irq); end
    rd(4'hC, v);
    n_cmp++; if (v !== 32'd2) begin n_err++; $display("FAIL rewe_claim: got %0h need 2", v); end
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    do_reset();
    src = 8'h03;
    wr(4'h4, 32'h03);
    tick(); tick(); tick(); tick(); tick();
    rd(4'hC, v);
    tick();
    n_cmp++; if (irq !== 1'b1 || rdata !== 32'd1) begin
      n_err++; $display("FAIL arst_setup: got irq=%b rdata=%0h need 1/1", irq, rdata);
    end
    #3;
    src = 8'h00;
    rst = 1'b1;
    #1;
    n_cmp++; if (irq !== 1'b0 || rdata !== 32'd0) begin
      n_err++; $display("FAIL arst_async: got irq=%b rdata=%0h need 0/0", irq, rdata);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int r = 0; r < 4; r++) begin
      rd(4'(r * 4), v);
      n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL arst_reg%0d: got %0h need 0", r, v); end
    end
  endtask

  task automatic test_random();
    logic [7:0]  s;
    logic        r, w;
    logic [3:0]  a;
    logic [31:0] d;
    do_reset();
    model_reset();
    s = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) s = s ^ 8'(1 << $urandom_range(0, 7));
      r = 1'b0; w = 1'b0; a = '0; d = '0;
      case ($urandom_range(0, 9))
        4: begin r = 1'b1; a = {2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))}; end
        5: begin r = 1'b1; a = 4'hC; end
        6: begin w = 1'b1; a = 4'hC; d = $urandom_range(0, 10); end
        7: begin w = 1'b1; a = ($urandom_range(0, 2) != 0) ? 4'h4 : 4'h8; d = $urandom; end
        8: begin w = 1'b1; a = 4'h0; d = $urandom; end
        9: begin r = 1'b1; w = 1'b1; a = {2'($urandom_range(0, 3)), 2'b00}; d = $urandom_range(0, 10); end
        default: ;
      endcase
      src = s; re = r; we = w; addr = a; wdata = d;
      model_edge(s, r, w, a, d);
      tick();
      n_cmp++; if (rdata !== m_rdata) begin
        n_err++; $display("FAIL rnd_rdata c=%0d: got %0h need %0h", c, rdata, m_rdata);
      end
      n_cmp++; if (irq !== m_irq) begin
        n_err++; $display("FAIL rnd_irq c=%0d: got %b need %b", c, irq, m_irq);
      end
    end
    re = 1'b0; we = 1'b0; src = '0;
  endtask

  initial begin
    test_reset();
    test_level();
    test_priority();
    test_edge_latch();
    test_set_vs_w1c();
    test_bad_complete();
    test_re_we();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt controller that drives the core's single `irq` input, which the exception unit samples. It collects `N_SRC` external interrupt sources and makes each one level- or edge-sensitive. It tracks pending and in-service state for every source and presents a claim/complete register interface on a small word-addressed bus. The block gives software one priority-resolved source ID per claim and keeps a serviced source from re-raising `irq` until software completes it.

## Interface
- `N_SRC`, default 8: number of interrupt sources, legal range 1..31.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `src`  in  N_SRC: raw interrupt lines, asynchronous to `clk`.
- `re`  in  1: register read strobe, one cycle.
- `we`  in  1: register write strobe, one cycle.
- `addr`  in  4: byte address, word aligned; `addr[3:2]` selects the register, `addr[1:0]` ignored.
- `wdata`  in  32: write data.
- `rdata`  out  32: read data, registered.
- `irq`  out  1: interrupt request to the core, registered.

## Operation
- Per-source state: two-flop synchronizer `s1`/`s2`, previous-sample flop `s_prev`, `pending`, `in_service`.
- Registers (by `addr[3:2]`):
  - 0 PENDING: read returns `pending`. Write is W1C on edge sources and ignored on level sources.
  - 1 ENABLE: read/write mask.
  - 2 EDGE: read/write mode; bit=1 edge-sensitive, bit=0 level-sensitive.
  - 3 CLAIM: read claims a source; write completes one.
- Bits at and above `N_SRC` are ignored on write and read as 0.
- Level source: `pending <= s2` every cycle.
- Edge source:
  - `pending` sets when `s2 && !s_prev`.
  - It clears on claim of that source or on W1C.
  - Set wins over clear in the same cycle.
- Writing EDGE clears `pending` for every source whose mode bit changes.
- Eligible set = `pending & ENABLE & ~in_service`.
- `irq <= |eligible`.
- CLAIM read:
  - `rdata <= index+1` of the lowest-index eligible source, or 0 if the set is empty.
  - On a nonzero result, in the same edge: `in_service[index] <= 1`, and the edge source's `pending` clears.
  - The claim resolves on register values of the `re` cycle.
- CLAIM write:
  - `wdata` = ID in 1..N_SRC clears `in_service[ID-1]`.
  - ID 0 or above `N_SRC` is ignored, and so is completing a source not in service.
- While in service, an edge source may latch a new `pending` but does not contribute to `irq` until completed.
- A level source still asserted at complete re-raises `irq`.
- `re` and `we` in the same cycle: the write is performed, the read is dropped, `rdata <= 0`, and no claim side effect occurs.
- Reads of any register other than CLAIM have no side effects.
- Reset values: all of `s1`, `s2`, `s_prev`, `pending`, `in_service`, ENABLE, EDGE, `rdata`, `irq` = 0. Asserting `rst` mid-operation drops all pending and in-service state immediately.

## Timing
- `rdata` is valid the cycle after `re` and holds until the next `re`/`we` cycle.
- `src` to `irq`:
  - Cycle 1: `src` sampled into `s1`. Cycle 2: `s2`. Cycle 3: `pending`. Cycle 4: `irq` high.
  - So 4 clock edges, counting the first sampling edge.
- Edge sources need `src` high for at least 2 consecutive sampled cycles to be guaranteed detected.
- Claim: the `re` edge sets `in_service`, and `irq` falls on the next edge if no other source is eligible.
- Complete: the `we` edge clears `in_service`, and `irq` can rise again on the next edge.
- ENABLE write takes effect on `irq` one edge after the write edge.
- No internal backpressure: every `re`/`we` completes in one cycle.

## Test plan
- Reset: after `rst` pulse, `irq`=0 and reads of all four registers return 0, including CLAIM returning 0.
- Level source: ENABLE=0x01, EDGE=0, `src[0]` high.
  - `irq`=1 on the 4th edge.
  - CLAIM returns 1 and `irq`=0 next cycle.
  - Complete 1 with `src[0]` still high: `irq` returns.
  - Drop `src[0]` and complete: `irq` stays 0.
- Priority: ENABLE=0xFF with `src[5]` and `src[2]` high.
  - CLAIM returns 3, then 6, then 0.
  - Completing 3 and reading CLAIM returns 3 again while `src[2]` is held.
- Edge latching: EDGE=ENABLE=0x10, pulse `src[4]` for 2 cycles.
  - CLAIM=5, then pulse again while in service: `irq` stays 0 and PENDING reads 0x10.
  - Complete 5: `irq`=1. Write PENDING=0x10: `irq`=0.
- Boundaries:
  - Edge-set coinciding with W1C leaves `pending`=1.
  - Complete with ID 0 or 9 changes nothing.
  - `re`+`we` together gives `rdata`=0 and no claim.
  - `rst` asserted with a source in service clears everything asynchronously.
